// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic               is_div;
    logic               neg_p;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        sa    = ~op[0] & a[WIDTH-1];
        sb    = ~op[0] & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;

        // Multiply: acc = {partial product, remaining multiplier bits}
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        // Divide: acc = {partial remainder, dividend/quotient}. The remainder is
        // always below the divisor, so bit WIDTH of the 33-bit difference is the borrow.
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};

        if (is_div)
            acc_nxt = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                       acc[WIDTH-2:0], ~diff[WIDTH]};
        else
            acc_nxt = {add_sum, acc[WIDTH-1:1]};

        prod_fix = neg_p ? -acc_nxt : acc_nxt;
        q_fix    = neg_p ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        r_fix    = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            a_raw  <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_p  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= op[1] && (b == '0);
                        a_raw  <= a;
                        opnd   <= op[1] ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (dz) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p, qv, rv;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'd0: begin p = sx * sy; return p; end
            2'd1: begin p = {32'b0, x} * {32'b0, y}; return p; end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy; r = sx % sy;
                qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op at the current negedge; MT writes are offered alongside start and must be dropped
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit disturb, input string tag);
        logic [63:0] r;
        int lat, nbusy;
        bit held;
        r = ref_model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 1; nbusy = 0; held = 1'b1;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
            if (disturb && lat == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (busy) nbusy++;
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " hi_lo"}, {hi, lo}, r);
        chk({tag, " held"}, 64'(held), 64'd1);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        @(negedge clk);
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'd33);
        chk({tag, " idle"}, {63'b0, busy | done}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset", {29'b0, busy, done, 1'b0, hi}, 64'd0);
        chk("reset lo", {32'b0, lo}, 64'd0);
        rst = 1'b0;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        do_op(2'd3, 32'd100, 32'd7, 1'b0, "divu");
        do_op(2'd3, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(2'd2, 32'h8765_4321, 32'd0, 1'b0, "div_zero_neg");
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_negb");
        do_op(2'd0, $urandom, $urandom, 1'b1, "disturb");

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both", {hi, lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_only", {hi, lo}, {32'h0BAD_F00D, 32'hDEAD_BEEF});
        exp_hi = 32'h0BAD_F00D; exp_lo = 32'hDEAD_BEEF;

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(ro, ra, rb, i[0], $sformatf("rand%0d", i));
        end

        op = 2'd0; a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", {30'b0, busy, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        do_op(2'd1, $urandom, $urandom, 1'b0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
